// File: rtl/isa_pkg.sv
// Shared ISA definitions for the program loader and the core's decoder.
// Holds the mnemonic codes, opcode constants, fixed NOP/HALT words, field
// bit positions, loader FSM states and loader error codes.
package isa_pkg;

    typedef enum logic [4:0] {
        MN_JMP     = 5'd0,
        MN_JMPR    = 5'd1,
        MN_JMPC    = 5'd2,
        MN_JMPRC   = 5'd3,
        MN_LOAD    = 5'd4,
        MN_STORE   = 5'd5,
        MN_LOADC   = 5'd6,
        MN_ADD     = 5'd7,
        MN_ADDF2   = 5'd8,
        MN_SUB     = 5'd9,
        MN_SUBF2   = 5'd10,
        MN_AND     = 5'd11,
        MN_OR      = 5'd12,
        MN_XOR     = 5'd13,
        MN_NAND    = 5'd14,
        MN_NOR     = 5'd15,
        MN_NXOR    = 5'd16,
        MN_SHIFTR  = 5'd17,
        MN_SHIFTRA = 5'd18,
        MN_SHIFTL  = 5'd19,
        MN_NOP     = 5'd20,
        MN_HALT    = 5'd21
    } mnem_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ILLEGAL  = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_e;

    // Opcode constants (4-bit jumps, 5-bit memory ops, 7-bit ALU/shift ops)
    localparam logic [3:0] OPC4_JMP     = 4'b0000;
    localparam logic [3:0] OPC4_JMPR    = 4'b0001;
    localparam logic [3:0] OPC4_JMPC    = 4'b0010;
    localparam logic [3:0] OPC4_JMPRC   = 4'b0011;
    localparam logic [4:0] OPC5_LOAD    = 5'b01000;
    localparam logic [4:0] OPC5_STORE   = 5'b01001;
    localparam logic [4:0] OPC5_LOADC   = 5'b01010;
    localparam logic [6:0] OPC7_ADD     = 7'b0101100;
    localparam logic [6:0] OPC7_SHIFTR  = 7'b0110110;

    localparam logic [15:0] WORD_NOP  = 16'h7200;
    localparam logic [15:0] WORD_HALT = 16'h73FF;

    // Field least-significant bit positions
    localparam int OPC4_LSB  = 12;
    localparam int OPC5_LSB  = 11;
    localparam int OPC7_LSB  = 9;
    localparam int COND_LSB  = 9;
    localparam int MOP0_LSB  = 8;   // op0 of LOAD/STORE/LOADC
    localparam int OP0_LSB   = 6;
    localparam int OP1_LSB   = 3;

endpackage

// File: rtl/instr_encode.sv
// Combinational instruction encoder: mnemonic plus fields -> 16-bit word.
// Ports: mnem_i, op0_i/op1_i/op2_i, cond_i, imm_i in; word_o (encoded word),
// legal_o (mnemonic is defined), range_err_o (offset/shift out of range) out.
module instr_encode
    import isa_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [2:0]  op0_i,
    input  logic [2:0]  op1_i,
    input  logic [2:0]  op2_i,
    input  logic [2:0]  cond_i,
    input  logic [7:0]  imm_i,
    output logic [15:0] word_o,
    output logic        legal_o,
    output logic        range_err_o
);

    logic [4:0] alu_idx_s;
    logic [4:0] shift_idx_s;
    logic       offset_bad_s;
    logic       shift_bad_s;

    // ALU and shift opcodes are consecutive in mnemonic order
    assign alu_idx_s    = mnem_i - 5'd7;
    assign shift_idx_s  = mnem_i - 5'd17;
    // Offset must be a sign-extended 6-bit value
    assign offset_bad_s = (imm_i[7:6] != {imm_i[5], imm_i[5]});
    assign shift_bad_s  = (imm_i[7:4] != 4'd0);

    // Word assembly and legality per mnemonic
    always_comb begin
        word_o      = 16'h0000;
        legal_o     = 1'b1;
        range_err_o = 1'b0;
        case (mnem_i)
            MN_JMP: begin
                word_o[OPC4_LSB +: 4] = OPC4_JMP;
                word_o[2:0]           = op0_i;
            end
            MN_JMPR: begin
                word_o[OPC4_LSB +: 4] = OPC4_JMPR;
                word_o[5:0]           = imm_i[5:0];
                range_err_o           = offset_bad_s;
            end
            MN_JMPC: begin
                word_o[OPC4_LSB +: 4] = OPC4_JMPC;
                word_o[COND_LSB +: 3] = cond_i;
                word_o[OP0_LSB +: 3]  = op0_i;
                word_o[2:0]           = op1_i;
            end
            MN_JMPRC: begin
                word_o[OPC4_LSB +: 4] = OPC4_JMPRC;
                word_o[COND_LSB +: 3] = cond_i;
                word_o[OP0_LSB +: 3]  = op0_i;
                word_o[5:0]           = imm_i[5:0];
                range_err_o           = offset_bad_s;
            end
            MN_LOAD, MN_STORE: begin
                word_o[OPC5_LSB +: 5] = (mnem_i == MN_LOAD) ? OPC5_LOAD : OPC5_STORE;
                word_o[MOP0_LSB +: 3] = op0_i;
                word_o[2:0]           = op1_i;
            end
            MN_LOADC: begin
                word_o[OPC5_LSB +: 5] = OPC5_LOADC;
                word_o[MOP0_LSB +: 3] = op0_i;
                word_o[7:0]           = imm_i;
            end
            MN_ADD, MN_ADDF2, MN_SUB, MN_SUBF2, MN_AND,
            MN_OR, MN_XOR, MN_NAND, MN_NOR, MN_NXOR: begin
                word_o[OPC7_LSB +: 7] = OPC7_ADD + {2'b00, alu_idx_s};
                word_o[OP0_LSB +: 3]  = op0_i;
                word_o[OP1_LSB +: 3]  = op1_i;
                word_o[2:0]           = op2_i;
            end
            MN_SHIFTR, MN_SHIFTRA, MN_SHIFTL: begin
                word_o[OPC7_LSB +: 7] = OPC7_SHIFTR + {2'b00, shift_idx_s};
                word_o[OP0_LSB +: 3]  = op0_i;
                word_o[3:0]           = imm_i[3:0];
                range_err_o           = shift_bad_s;
            end
            MN_NOP:  word_o = WORD_NOP;
            MN_HALT: word_o = WORD_HALT;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts mnemonic commands over valid/ready, encodes them
// and writes the words to sequential instruction-memory addresses.
// Ports: start/base_addr open a session; cmd_* is the command handshake;
// imem_* is the memory write port (held until imem_ready); busy/done/err/
// err_code/word_count report session status.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_mnem,
    input  logic [2:0]        cmd_op0,
    input  logic [2:0]        cmd_op1,
    input  logic [2:0]        cmd_op2,
    input  logic [2:0]        cmd_cond,
    input  logic [7:0]        cmd_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              we_q;
    logic              halt_q;
    logic              wrapped_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic [ADDR_W:0]   word_count_q;

    logic [15:0]       enc_word_s;
    logic              enc_legal_s;
    logic              enc_range_err_s;
    logic              cmd_is_halt_s;

    instr_encode u_encode (
        .mnem_i      (cmd_mnem),
        .op0_i       (cmd_op0),
        .op1_i       (cmd_op1),
        .op2_i       (cmd_op2),
        .cond_i      (cmd_cond),
        .imm_i       (cmd_imm),
        .word_o      (enc_word_s),
        .legal_o     (enc_legal_s),
        .range_err_o (enc_range_err_s)
    );

    assign cmd_is_halt_s = (cmd_mnem == MN_HALT);

    // Session FSM with address counter, memory handshake and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            we_q         <= 1'b0;
            halt_q       <= 1'b0;
            wrapped_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            word_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q      <= ST_ACCEPT;
                        addr_q       <= base_addr;
                        word_count_q <= '0;
                        wrapped_q    <= 1'b0;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        err_code_q   <= ERR_NONE;
                        cmd_ready_q  <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (!enc_legal_s) begin
                            state_q    <= ST_ERROR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_ILLEGAL;
                            busy_q     <= 1'b0;
                        end else if (enc_range_err_s) begin
                            state_q    <= ST_ERROR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RANGE;
                            busy_q     <= 1'b0;
                        end else if (wrapped_q && !cmd_is_halt_s) begin
                            // Memory already full; only a closing HALT may still go in
                            state_q    <= ST_ERROR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_OVERFLOW;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= ST_WRITE;
                            we_q    <= 1'b1;
                            wdata_q <= enc_word_s;
                            halt_q  <= cmd_is_halt_s;
                        end
                    end
                end
                ST_WRITE: begin
                    if (imem_ready) begin
                        we_q         <= 1'b0;
                        word_count_q <= word_count_q + {{ADDR_W{1'b0}}, 1'b1};
                        if (halt_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= ST_ACCEPT;
                            cmd_ready_q <= 1'b1;
                            if (addr_q == ADDR_MAX) begin
                                addr_q    <= '0;
                                wrapped_q <= 1'b1;
                            end else begin
                                addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed scenarios plus random
// sessions, checked against an arithmetic reference model of the encoding.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_mnem = 5'd0;
    logic [2:0]  cmd_op0 = 3'd0, cmd_op1 = 3'd0, cmd_op2 = 3'd0, cmd_cond = 3'd0;
    logic [7:0]  cmd_imm = 8'h00;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_ready = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    instr_encoder_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mnem(cmd_mnem),
        .cmd_op0(cmd_op0), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .cmd_cond(cmd_cond), .cmd_imm(cmd_imm), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
    wr_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int ready_hold = 0;
    int m_addr = 0;
    int m_count = 0;
    bit m_wrapped = 1'b0;
    bit in_sess = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // Reference encoding built from field weights
    function automatic logic [15:0] ref_word(int m, int a, int b, int c, int cd, int im);
        int w;
        w = 0;
        if (m == 0)                 w = a;
        else if (m == 1)            w = 1 * 4096 + (im % 64);
        else if (m == 2)            w = 2 * 4096 + cd * 512 + a * 64 + b;
        else if (m == 3)            w = 3 * 4096 + cd * 512 + a * 64 + (im % 64);
        else if (m >= 4 && m <= 5)  w = (m + 4) * 2048 + a * 256 + b;
        else if (m == 6)            w = 10 * 2048 + a * 256 + im;
        else if (m <= 16)           w = (44 + m - 7) * 512 + a * 64 + b * 8 + c;
        else if (m <= 19)           w = (54 + m - 17) * 512 + a * 64 + im;
        else if (m == 20)           w = 'h7200;
        else                        w = 'h73FF;
        return 16'(w);
    endfunction

    function automatic int classify(int m, int im);
        int v;
        if (m > 21) return 1;
        v = (im >= 128) ? im - 256 : im;
        if ((m == 1 || m == 3) && (v < -32 || v > 31)) return 2;
        if (m >= 17 && m <= 19 && im > 15) return 2;
        if (m_wrapped && m != 21) return 3;
        return 0;
    endfunction

    // Memory-side readiness: forced low while a hold is requested, else random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_hold > 0) begin
                imem_ready = 1'b0;
                if (imem_we) ready_hold--;
            end else begin
                imem_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: checks held write data and pops the scoreboard on each write
    initial begin
        bit pend;
        logic [7:0] p_addr;
        logic [15:0] p_data;
        wr_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_we) begin
                if (pend) begin
                    check("hold_addr", 32'(imem_addr), 32'(p_addr));
                    check("hold_data", 32'(imem_wdata), 32'(p_data));
                end
                if (imem_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(imem_addr), 32'(e.addr));
                        check("wr_data", 32'(imem_wdata), 32'(e.data));
                    end
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    p_addr = imem_addr;
                    p_data = imem_wdata;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic do_start(input logic [7:0] base);
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 8'($urandom);
        m_addr = int'(base);
        m_count = 0;
        m_wrapped = 1'b0;
        in_sess = 1'b1;
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(cmd_ready), 32'd1);
        check("start_flags", {29'd0, done, err, 2'b00} | 32'(err_code), 32'd0);
        check("start_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            fail_now("done_timeout");
        end else begin
            check("done_qempty", 32'(exp_q.size()), 32'd0);
            check("done_count", 32'(word_count), 32'(m_count));
            check("done_ready", 32'(cmd_ready), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
            check("done_err", 32'(err), 32'd0);
        end
    endtask

    task automatic send_cmd(input int m, input int a, input int b, input int c,
                            input int cd, input int im, input int lit);
        int code;
        bit ok;
        logic [15:0] w;
        ok = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        cmd_valid = 1'b1;
        cmd_mnem = 5'(m); cmd_op0 = 3'(a); cmd_op1 = 3'(b); cmd_op2 = 3'(c);
        cmd_cond = 3'(cd); cmd_imm = 8'(im);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            fail_now("cmd_ready_timeout");
            cmd_valid = 1'b0;
            in_sess = 1'b0;
            @(posedge clk); #1;
            return;
        end
        code = classify(m, im);
        w = (lit >= 0) ? 16'(lit) : ref_word(m, a, b, c, cd, im);
        if (code == 0) exp_q.push_back('{8'(m_addr), w});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_mnem = 5'($urandom); cmd_imm = 8'($urandom);
        if (code != 0) begin
            @(negedge clk);
            check("err_flag", 32'(err), 32'd1);
            check("err_code", 32'(err_code), 32'(code));
            check("err_nowrite", 32'(imem_we), 32'd0);
            check("err_ready", 32'(cmd_ready), 32'd0);
            check("err_count", 32'(word_count), 32'(m_count));
            in_sess = 1'b0;
        end else begin
            m_count++;
            if (m == 21) begin
                wait_done();
                in_sess = 1'b0;
            end else if (m_addr == 255) begin
                m_addr = 0;
                m_wrapped = 1'b1;
            end else begin
                m_addr++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !imem_we) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("drain_timeout");
        else check("drain_count", 32'(word_count), 32'(m_count));
        @(posedge clk); #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int m, im, r;
        logic [7:0] base;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_outputs", {24'd0, busy, done, err, cmd_ready, imem_we, err_code, 1'b0}, 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;

        // ADD, ignored start, held LOADC, STORE, JMPRC, bad JMPR
        do_start(8'h10);
        send_cmd(7, 1, 2, 3, 0, 0, 'h5853);
        wait_drain();
        start = 1'b1; base_addr = 8'h80;
        @(posedge clk); #1;
        start = 1'b0;
        ready_hold = 3;
        send_cmd(6, 5, 0, 0, 0, 'hA7, 'h55A7);
        send_cmd(5, 2, 6, 0, 0, 0, 'h4A06);
        send_cmd(3, 4, 0, 0, 3, 'hFE, 'h373E);
        send_cmd(1, 0, 0, 0, 0, 'h40, -1);

        // SHIFTL then HALT
        do_start(8'h20);
        send_cmd(19, 3, 0, 0, 0, 5, 'h70C5);
        send_cmd(21, 0, 0, 0, 0, 0, 'h73FF);

        // Wrap at top of memory, then overflow; HALT still allowed at the top
        do_start(8'hFF);
        send_cmd(20, 0, 0, 0, 0, 0, 'h7200);
        send_cmd(7, 1, 1, 1, 0, 0, -1);
        do_start(8'hFF);
        send_cmd(21, 0, 0, 0, 0, 0, 'h73FF);

        // Illegal mnemonic
        do_start(8'h00);
        send_cmd(25, 0, 0, 0, 0, 0, -1);

        // Random sessions
        for (int s = 0; s < 40; s++) begin
            base = ($urandom_range(0, 3) == 0) ? 8'(253 + $urandom_range(0, 2)) : 8'($urandom);
            do_start(base);
            for (int k = 0; k < 10 && in_sess; k++) begin
                r = $urandom_range(0, 99);
                m = (r < 4) ? $urandom_range(22, 31) : (r < 10) ? 21 : $urandom_range(0, 20);
                if (k == 9) m = 21;
                if ($urandom_range(0, 1) == 0) im = $urandom_range(0, 255);
                else if (m >= 17 && m <= 19) im = $urandom_range(0, 15);
                else im = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range(224, 255);
                send_cmd(m, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), im, -1);
            end
        end

        // Reset in the middle of a held write
        do_start(8'h30);
        ready_hold = 1000;
        send_cmd(9, 4, 5, 6, 0, 0, -1);
        check("pre_rst_we", 32'(imem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_we_drop", 32'(imem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mid_count", 32'(word_count), 32'd0);
        exp_q.delete();
        ready_hold = 0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        cmd_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd0);
        check("idle_we", 32'(imem_we), 32'd0);
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
